// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the riscv core front end.
//   XLEN             - architectural register / address width
//   INST_NOP         - canonical NOP (addi x0, x0, 0) shown when no instruction is valid
//   RESET_PC_DEFAULT - default first fetch address after reset
//   if_entry_t       - one fetch buffer entry {pc, inst, filled}
//   align_word()     - forces an address onto a 32-bit word boundary
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            filled;
  } if_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_entry_buf.sv
// if_entry_buf: DEPTH-entry circular buffer of fetch slots.
// A slot is allocated (pc written, filled cleared) when a ROM request is
// accepted, filled (inst written, filled set) when its response returns, and
// popped when decode takes it. Three wrap-bit pointers track the slot order:
//   head_ptr <= fill_ptr <= alloc_ptr
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   i_alloc/i_alloc_pc - allocate the slot at alloc_ptr with this pc
//   i_fill/i_fill_inst - complete the slot at fill_ptr with this instruction
//   i_pop           - release the slot at head_ptr
//   i_flush         - drop every slot; all pointers collapse onto alloc_ptr
//   o_head          - contents of the head slot
//   o_occupancy     - alloc_ptr - head_ptr (slots in use)
//   o_pending       - alloc_ptr - fill_ptr (requests awaiting a response)
module if_entry_buf
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_alloc,
  input  logic [XLEN-1:0]  i_alloc_pc,
  input  logic             i_fill,
  input  logic [XLEN-1:0]  i_fill_inst,
  input  logic             i_pop,
  input  logic             i_flush,
  output if_entry_t        o_head,
  output logic [PTR_W-1:0] o_occupancy,
  output logic [PTR_W-1:0] o_pending
);

  logic [XLEN-1:0]  r_pc   [DEPTH];
  logic [XLEN-1:0]  r_inst [DEPTH];
  logic [DEPTH-1:0] r_filled;

  logic [PTR_W-1:0] r_alloc_ptr;
  logic [PTR_W-1:0] r_fill_ptr;
  logic [PTR_W-1:0] r_head_ptr;

  logic [IDX_W-1:0] w_alloc_idx;
  logic [IDX_W-1:0] w_fill_idx;
  logic [IDX_W-1:0] w_head_idx;
  logic [DEPTH-1:0] w_filled_nxt;

  assign w_alloc_idx = r_alloc_ptr[IDX_W-1:0];
  assign w_fill_idx  = r_fill_ptr[IDX_W-1:0];
  assign w_head_idx  = r_head_ptr[IDX_W-1:0];

  // The three slots touched in one cycle are always distinct: fill needs
  // fill_ptr != alloc_ptr, pop needs a filled head (head_ptr < fill_ptr), and
  // alloc only happens while the buffer is not full.
  always_comb begin
    w_filled_nxt = r_filled;
    if (i_alloc) w_filled_nxt[w_alloc_idx] = 1'b0;
    if (i_fill)  w_filled_nxt[w_fill_idx]  = 1'b1;
    if (i_pop)   w_filled_nxt[w_head_idx]  = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_filled    <= '0;
    end else if (i_flush) begin
      // Clear every filled bit so a stale slot can never surface at the new head.
      r_fill_ptr <= r_alloc_ptr;
      r_head_ptr <= r_alloc_ptr;
      r_filled   <= '0;
    end else begin
      if (i_alloc) r_alloc_ptr <= r_alloc_ptr + PTR_W'(1);
      if (i_fill)  r_fill_ptr  <= r_fill_ptr + PTR_W'(1);
      if (i_pop)   r_head_ptr  <= r_head_ptr + PTR_W'(1);
      r_filled <= w_filled_nxt;
    end
  end

  // Payload storage carries no reset; the filled bits qualify it.
  always_ff @(posedge clk) begin
    if (i_alloc && !i_flush) r_pc[w_alloc_idx]  <= i_alloc_pc;
    if (i_fill && !i_flush)  r_inst[w_fill_idx] <= i_fill_inst;
  end

  always_comb begin
    o_head.pc     = r_pc[w_head_idx];
    o_head.inst   = r_inst[w_head_idx];
    o_head.filled = r_filled[w_head_idx];
  end

  assign o_occupancy = r_alloc_ptr - r_head_ptr;
  assign o_pending   = r_alloc_ptr - r_fill_ptr;

endmodule

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: instruction-fetch front end between the instruction ROM and
// the if_id register. Issues pipelined word fetches with a grant handshake,
// tolerates any in-order ROM latency, buffers up to DEPTH instructions and
// hands them to decode over valid/ready. A redirect flushes the buffer and
// counts the requests still in flight so their responses get discarded.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   rom_ce_o, rom_addr_o       - ROM request valid / word address
//   rom_gnt_i                  - ROM accepts the request this cycle
//   rom_rvalid_i, rom_data_i   - in-order ROM response
//   redirect_i, redirect_pc_i  - branch/jump redirect and its target
//   if_valid_o, if_pc_o, if_inst_o - instruction presented to decode
//   id_ready_i                 - decode accepts the presented instruction
module if_fetch_buf
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_gnt_i,
  input  logic        rom_rvalid_i,
  input  logic [31:0] rom_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  input  logic        id_ready_i
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [XLEN-1:0]  r_fetch_pc;
  logic [PTR_W-1:0] r_drop_cnt;

  if_entry_t        w_head;
  logic [PTR_W-1:0] w_occupancy;
  logic [PTR_W-1:0] w_pending;
  logic [PTR_W:0]   w_committed;
  logic             w_has_credit;
  logic             w_issue;
  logic             w_drop;
  logic             w_fill;
  logic             w_pop;
  logic             w_rsp_used;

  // Slots in use plus responses still owed for discarded requests; the ROM
  // never holds more than DEPTH requests, so this bounds issue.
  assign w_committed  = {1'b0, w_occupancy} + {1'b0, r_drop_cnt};
  assign w_has_credit = (w_committed < DEPTH_CNT);

  // rst_n in the gate keeps the request low while reset is held and lets the
  // first request go out in the very first clock after release.
  assign rom_ce_o   = rst_n && w_has_credit && !redirect_i;
  assign rom_addr_o = r_fetch_pc;

  assign w_issue = rom_ce_o && rom_gnt_i;
  assign w_pop   = if_valid_o && id_ready_i;

  // Stale responses are discarded whenever they arrive, even while issue is
  // blocked, so a fully drained credit window can always recover.
  assign w_drop = rom_rvalid_i && (r_drop_cnt != '0);
  assign w_fill = rom_rvalid_i && (r_drop_cnt == '0) && (w_pending != '0) && !redirect_i;

  // A response this cycle retires one in-flight request (stale or live);
  // a response with nothing outstanding retires nothing.
  assign w_rsp_used = rom_rvalid_i && ((r_drop_cnt != '0) || (w_pending != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_drop_cnt <= '0;
    end else if (redirect_i) begin
      r_fetch_pc <= align_word(redirect_pc_i);
      r_drop_cnt <= r_drop_cnt + w_pending - PTR_W'(w_rsp_used);
    end else begin
      if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_drop)  r_drop_cnt <= r_drop_cnt - PTR_W'(1);
    end
  end

  if_entry_buf #(
    .DEPTH (DEPTH)
  ) u_entry_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_alloc     (w_issue),
    .i_alloc_pc  (r_fetch_pc),
    .i_fill      (w_fill),
    .i_fill_inst (rom_data_i),
    .i_pop       (w_pop),
    .i_flush     (redirect_i),
    .o_head      (w_head),
    .o_occupancy (w_occupancy),
    .o_pending   (w_pending)
  );

  assign if_valid_o = w_head.filled;
  assign if_pc_o    = w_head.filled ? w_head.pc   : '0;
  assign if_inst_o  = w_head.filled ? w_head.inst : INST_NOP;

endmodule

// File: tb/tb_if_fetch_buf.sv
// Testbench for if_fetch_buf: in-order ROM model with configurable latency
// and a scoreboard of granted PCs compared against what decode receives.
module tb_if_fetch_buf;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic        rom_gnt_i = 1'b0;
  logic        rom_rvalid_i = 1'b0;
  logic [31:0] rom_data_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        id_ready_i = 1'b0;

  if_fetch_buf #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom_ce_o      (rom_ce_o),
    .rom_addr_o    (rom_addr_o),
    .rom_gnt_i     (rom_gnt_i),
    .rom_rvalid_i  (rom_rvalid_i),
    .rom_data_i    (rom_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_inst_o     (if_inst_o),
    .id_ready_i    (id_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        rom_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] pq[$];
  logic [31:0] piq[$];
  logic [31:0] gq[$];

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 1;
  int          g_cnt = 0;
  int          pops = 0;
  logic        gnt_k = 1'b1;
  logic        rdy_k = 1'b1;
  logic        redir_k = 1'b0;
  logic        spur_k = 1'b0;
  logic [31:0] redir_pc_k = '0;

  logic        s_ce, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a << 8) ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, update the
  // ROM model and scoreboard for what the rising edge will commit.
  task automatic step();
    logic rv;
    req_t tmp;
    logic [31:0] e;
    rv = (rom_q.size() > 0) && (rom_q[0].due <= cyc);
    rom_gnt_i     = gnt_k;
    id_ready_i    = rdy_k;
    redirect_i    = redir_k;
    redirect_pc_i = redir_pc_k;
    rom_rvalid_i  = rv || (spur_k && (rom_q.size() == 0));
    rom_data_i    = rv ? rom_word(rom_q[0].addr) : 32'hDEAD_BEEF;
    #1;
    s_ce = rom_ce_o; s_addr = rom_addr_o;
    s_valid = if_valid_o; s_pc = if_pc_o; s_inst = if_inst_o;
    if (if_valid_o && id_ready_i) begin
      pops++;
      pq.push_back(if_pc_o);
      piq.push_back(if_inst_o);
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {31'b0, if_valid_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", if_pc_o, e);
        chk("pop_inst", if_inst_o, rom_word(e));
      end
    end
    if (rv) tmp = rom_q.pop_front();
    if (redir_k) exp_q.delete();
    if (rom_ce_o && rom_gnt_i) begin
      rom_q.push_back('{rom_addr_o, cyc + lat});
      exp_q.push_back(rom_addr_o);
      gq.push_back(rom_addr_o);
      g_cnt++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rom_q.delete(); exp_q.delete(); pq.delete(); piq.delete(); gq.delete();
    gnt_k = 1'b1; rdy_k = 1'b1; redir_k = 1'b0; spur_k = 1'b0; lat = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int p0;
    repeat (2) @(negedge clk);
    chk("rst_ce",    {31'b0, rom_ce_o}, 32'd0);
    chk("rst_addr",  rom_addr_o, 32'h0);
    chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
    chk("rst_pc",    if_pc_o, 32'h0);
    chk("rst_inst",  if_inst_o, INST_NOP);

    // 1: back-to-back fetch with a 1-cycle ROM
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t1_ce", {31'b0, s_ce}, 32'd1);
      chk("t1_addr", s_addr, 32'(4 * i));
      chk("t1_valid", {31'b0, s_valid}, (i >= 2) ? 32'd1 : 32'd0);
      if (i >= 2) chk("t1_pc", s_pc, 32'(4 * (i - 2)));
    end

    // 2: decode stalled fills exactly DEPTH slots; stray rvalid ignored
    do_reset();
    rdy_k = 1'b0; g_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      spur_k = (i >= 6);
      step();
    end
    chk("t2_grants", 32'(g_cnt), 32'd4);
    chk("t2_ce_full", {31'b0, s_ce}, 32'd0);
    chk("t2_head_pc", s_pc, 32'h0);
    spur_k = 1'b0; rdy_k = 1'b1; pq.delete(); gq.delete();
    for (int i = 0; i < 8; i++) step();
    if (pq.size() < 4) chk("t2_pop_count", 32'(pq.size()), 32'd4);
    else for (int i = 0; i < 4; i++) chk("t2_pop_order", pq[i], 32'(4 * i));
    if (gq.size() < 1) chk("t2_resume_count", 32'(gq.size()), 32'd1);
    else chk("t2_resume_addr", gq[0], 32'h10);

    // 3: redirect with 3 requests in flight on a slow ROM
    do_reset();
    lat = 4;
    for (int i = 0; i < 3; i++) step();
    redir_k = 1'b1; redir_pc_k = 32'h0000_0200;
    step();
    chk("t3_no_issue", {31'b0, s_ce}, 32'd0);
    redir_k = 1'b0; pq.delete(); piq.delete();
    step();
    chk("t3_target_ce", {31'b0, s_ce}, 32'd1);
    chk("t3_target_addr", s_addr, 32'h200);
    for (int i = 0; i < 20 && pq.size() == 0; i++) step();
    if (pq.size() == 0) chk("t3_first_pop_timeout", 32'd0, 32'd1);
    else begin
      chk("t3_first_pc", pq[0], 32'h200);
      chk("t3_first_inst", piq[0], rom_word(32'h200));
    end

    // 4: misaligned redirect target
    lat = 1;
    redir_k = 1'b1; redir_pc_k = 32'h0000_0103;
    step();
    redir_k = 1'b0;
    step();
    chk("t4_ce", {31'b0, s_ce}, 32'd1);
    chk("t4_aligned_addr", s_addr, 32'h100);
    for (int i = 0; i < 10; i++) step();

    // 5: grant withheld at 0x8
    do_reset();
    step(); step();
    gnt_k = 1'b0; g_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_addr_hold", s_addr, 32'h8);
    end
    chk("t5_no_alloc", 32'(g_cnt), 32'd0);
    gnt_k = 1'b1; gq.delete();
    step(); step();
    if (gq.size() < 2) chk("t5_grant_count", 32'(gq.size()), 32'd2);
    else begin
      chk("t5_grant0", gq[0], 32'h8);
      chk("t5_grant1", gq[1], 32'hC);
    end
    for (int i = 0; i < 6; i++) step();

    // 6: asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) step();
    chk("t6_pre_valid", {31'b0, s_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ce",    {31'b0, rom_ce_o}, 32'd0);
    chk("t6_addr",  rom_addr_o, 32'h0);
    chk("t6_valid", {31'b0, if_valid_o}, 32'd0);
    chk("t6_pc",    if_pc_o, 32'h0);
    chk("t6_inst",  if_inst_o, INST_NOP);
    rom_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; cyc = 0;
    step();
    chk("t6_restart_ce", {31'b0, s_ce}, 32'd1);
    chk("t6_restart_addr", s_addr, 32'h0);
    for (int i = 0; i < 6; i++) step();

    // 7: 2-cycle ROM sustains one instruction per cycle
    do_reset();
    lat = 2;
    for (int i = 0; i < 6; i++) step();
    p0 = pops;
    for (int i = 0; i < 12; i++) step();
    chk("t7_throughput", 32'(pops - p0), 32'd12);

    // drain: every granted PC must reach decode
    gnt_k = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
